// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing, coordinate width, colour codes,
// ball state record and the per-axis wall-reflection step.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int COORD_W  = 11;

    // Colour codes, bit order {R,G,B}
    localparam logic [2:0] RGB_BLACK = 3'b000;
    localparam logic [2:0] RGB_BLUE  = 3'b001;
    localparam logic [2:0] RGB_GREEN = 3'b010;
    localparam logic [2:0] RGB_CYAN  = 3'b011;
    localparam logic [2:0] RGB_RED   = 3'b100;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               vx_neg;
        logic               vy_neg;
    } ball_t;

    typedef struct packed {
        logic [COORD_W-1:0] pos;
        logic               neg;
    } axis_t;

    // Colour of ball idx: code idx+1
    function automatic logic [2:0] ball_rgb(input int idx);
        logic [2:0] code;
        case (idx)
            0:       code = RGB_BLUE;
            1:       code = RGB_GREEN;
            2:       code = RGB_CYAN;
            3:       code = RGB_RED;
            default: code = RGB_BLACK;
        endcase
        return code;
    endfunction

    // One step along an axis; signed 12-bit so a move below zero cannot wrap
    function automatic axis_t step_axis(input logic [COORD_W-1:0] pos,
                                        input logic               neg,
                                        input logic [2:0]         step,
                                        input logic [COORD_W-1:0] lo,
                                        input logic [COORD_W-1:0] hi);
        logic signed [11:0] n;
        axis_t              res;
        if (neg) begin
            n = $signed({1'b0, pos}) - $signed({9'b0, step});
        end else begin
            n = $signed({1'b0, pos}) + $signed({9'b0, step});
        end
        if (n > $signed({1'b0, hi})) begin
            res.pos = hi;
            res.neg = 1'b1;
        end else if (n < $signed({1'b0, lo})) begin
            res.pos = lo;
            res.neg = 1'b0;
        end else begin
            res.pos = n[COORD_W-1:0];
            res.neg = neg;
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider, raster counters, raw sync windows, active flag and
// the once-per-frame update strobe (first blanking line, hcnt==0).
module vga_timing #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_pe,
    output logic [10:0] o_hcnt,
    output logic [10:0] o_vcnt,
    output logic        o_active,
    output logic        o_hsync_raw,
    output logic        o_vsync_raw,
    output logic        o_update
);
    import vga_pkg::*;

    localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic [10:0]      r_hcnt;
    logic [10:0]      r_vcnt;
    logic             w_pe;

    assign w_pe = (r_div == DIV_W'(CLK_DIV - 1));

    // Clock divider producing one pixel enable every CLK_DIV cycles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div <= '0;
        end else if (w_pe) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Raster position: hcnt wraps each line, vcnt wraps each frame
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hcnt <= 11'd0;
            r_vcnt <= 11'd0;
        end else if (w_pe) begin
            if (r_hcnt == 11'(HT - 1)) begin
                r_hcnt <= 11'd0;
                if (r_vcnt == 11'(VT - 1)) begin
                    r_vcnt <= 11'd0;
                end else begin
                    r_vcnt <= r_vcnt + 11'd1;
                end
            end else begin
                r_hcnt <= r_hcnt + 11'd1;
            end
        end
    end

    assign o_pe        = w_pe;
    assign o_hcnt      = r_hcnt;
    assign o_vcnt      = r_vcnt;
    assign o_active    = (r_hcnt < 11'(H_ACTIVE)) && (r_vcnt < 11'(V_ACTIVE));
    assign o_hsync_raw = !((r_hcnt >= 11'(H_ACTIVE + H_FP)) &&
                           (r_hcnt <  11'(H_ACTIVE + H_FP + H_SYNC)));
    assign o_vsync_raw = !((r_vcnt >= 11'(V_ACTIVE + V_FP)) &&
                           (r_vcnt <  11'(V_ACTIVE + V_FP + V_SYNC)));
    assign o_update    = w_pe && (r_hcnt == 11'd0) && (r_vcnt == 11'(V_ACTIVE));

endmodule

// File: rtl/multi_bounce_vga.sv
// N_BALLS bouncing filled circles on a VGA raster. Ball state moves only in
// vertical blanking; sync and colour are registered together one pixel late.
module multi_bounce_vga #(
    parameter int N_BALLS   = 2,
    parameter int RADIUS    = 16,
    parameter int CLK_DIV   = 2,
    parameter int FRAME_DIV = 1,
    parameter int H_ACTIVE  = vga_pkg::H_ACTIVE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_ACTIVE  = vga_pkg::V_ACTIVE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PAUSE,
    input  logic [1:0] SPEED,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       R,
    output logic       G,
    output logic       B
);
    import vga_pkg::*;

    localparam logic [10:0] X_HI  = 11'(H_ACTIVE - 1 - RADIUS);
    localparam logic [10:0] Y_HI  = 11'(V_ACTIVE - 1 - RADIUS);
    localparam logic [10:0] LO    = 11'(RADIUS);
    localparam logic [23:0] R_SQ  = 24'(RADIUS * RADIUS);

    logic        w_pe;
    logic [10:0] w_hcnt;
    logic [10:0] w_vcnt;
    logic        w_active;
    logic        w_hsync_raw;
    logic        w_vsync_raw;
    logic        w_update;

    ball_t               r_ball      [N_BALLS];
    ball_t               w_ball_next [N_BALLS];
    logic [N_BALLS-1:0]  w_hit;
    logic [3:0]          r_frame_cnt;
    logic [2:0]          w_step;
    logic [2:0]          w_pix_rgb;
    logic                r_hsync;
    logic                r_vsync;
    logic [2:0]          r_rgb;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .i_clk       (CLK),
        .i_rst       (RESET),
        .o_pe        (w_pe),
        .o_hcnt      (w_hcnt),
        .o_vcnt      (w_vcnt),
        .o_active    (w_active),
        .o_hsync_raw (w_hsync_raw),
        .o_vsync_raw (w_vsync_raw),
        .o_update    (w_update)
    );

    assign w_step = {1'b0, SPEED} + 3'd1;

    for (genvar gi = 0; gi < N_BALLS; gi++) begin : g_ball
        logic signed [11:0] w_dx;
        logic signed [11:0] w_dy;
        logic signed [23:0] w_dx_w;
        logic signed [23:0] w_dy_w;
        logic signed [23:0] w_dx2;
        logic signed [23:0] w_dy2;
        logic        [23:0] w_dist;
        axis_t              w_xa;
        axis_t              w_ya;

        assign w_dx   = $signed({1'b0, w_hcnt}) - $signed({1'b0, r_ball[gi].x});
        assign w_dy   = $signed({1'b0, w_vcnt}) - $signed({1'b0, r_ball[gi].y});
        assign w_dx_w = 24'(w_dx);
        assign w_dy_w = 24'(w_dy);
        assign w_dx2  = w_dx_w * w_dx_w;
        assign w_dy2  = w_dy_w * w_dy_w;
        assign w_dist = $unsigned(w_dx2) + $unsigned(w_dy2);
        assign w_hit[gi] = (w_dist <= R_SQ);

        assign w_xa = step_axis(r_ball[gi].x, r_ball[gi].vx_neg, w_step, LO, X_HI);
        assign w_ya = step_axis(r_ball[gi].y, r_ball[gi].vy_neg, w_step, LO, Y_HI);
        assign w_ball_next[gi] = '{x: w_xa.pos, y: w_ya.pos,
                                   vx_neg: w_xa.neg, vy_neg: w_ya.neg};
    end

    // Priority mux: scan from highest index down so the lowest index wins
    always_comb begin
        w_pix_rgb = RGB_BLACK;
        for (int i = N_BALLS - 1; i >= 0; i--) begin
            w_pix_rgb = w_hit[i] ? ball_rgb(i) : w_pix_rgb;
        end
    end

    // Frame divider and ball motion, only at the blanking update strobe
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_frame_cnt <= 4'd0;
            for (int i = 0; i < N_BALLS; i++) begin
                r_ball[i] <= '{x: 11'(100 + 64 * i), y: 11'(100 + 48 * i),
                               vx_neg: 1'(i % 2), vy_neg: 1'b0};
            end
        end else if (w_update && !PAUSE) begin
            if (r_frame_cnt == 4'(FRAME_DIV - 1)) begin
                r_frame_cnt <= 4'd0;
                for (int i = 0; i < N_BALLS; i++) begin
                    r_ball[i] <= w_ball_next[i];
                end
            end else begin
                r_frame_cnt <= r_frame_cnt + 4'd1;
            end
        end
    end

    // Output stage: sync and colour registered together on the pixel enable
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= RGB_BLACK;
        end else if (w_pe) begin
            r_hsync <= w_hsync_raw;
            r_vsync <= w_vsync_raw;
            r_rgb   <= w_active ? w_pix_rgb : RGB_BLACK;
        end
    end

    assign HSYNC = r_hsync;
    assign VSYNC = r_vsync;
    assign R     = r_rgb[2];
    assign G     = r_rgb[1];
    assign B     = r_rgb[0];

endmodule

// File: tb/tb_multi_bounce_vga.sv
// Bench for multi_bounce_vga on a shrunken raster so whole frames fit in a
// short run. A pixel-level reference model tracks the raster and the balls
// with plain integers and predicts every output on every clock.
module tb_multi_bounce_vga;

    localparam int NB   = 2;
    localparam int RAD  = 4;
    localparam int CDIV = 2;
    localparam int FDIV = 2;
    localparam int HA = 140, HF = 2, HS = 4, HB = 2;
    localparam int VA = 16,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME_CYC = HT * VT * CDIV;

    logic       clk = 1'b0;
    logic       RESET;
    logic       PAUSE;
    logic [1:0] SPEED;
    logic       HSYNC, VSYNC, R, G, B;

    always #5 clk = ~clk;

    multi_bounce_vga #(
        .N_BALLS(NB), .RADIUS(RAD), .CLK_DIV(CDIV), .FRAME_DIV(FDIV),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .CLK(clk), .RESET(RESET), .PAUSE(PAUSE), .SPEED(SPEED),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .R(R), .G(G), .B(B)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // reference model state
    int         m_div, m_h, m_v, m_frame;
    int         bx [NB];
    int         by [NB];
    bit         bxn [NB];
    bit         byn [NB];
    bit         e_hs, e_vs;
    logic [2:0] e_rgb;

    task automatic axis_step(input int p, input bit neg, input int s, input int hi,
                             output int np, output bit nn);
        int n;
        n = neg ? p - s : p + s;
        if (n > hi) begin
            np = hi; nn = 1'b1;
        end else if (n < RAD) begin
            np = RAD; nn = 1'b0;
        end else begin
            np = n; nn = neg;
        end
    endtask

    task automatic model_step();
        int s;
        if (RESET) begin
            m_div = 0; m_h = 0; m_v = 0; m_frame = 0;
            e_hs = 1'b1; e_vs = 1'b1; e_rgb = 3'd0;
            for (int i = 0; i < NB; i++) begin
                bx[i] = 100 + 64 * i; by[i] = 100 + 48 * i;
                bxn[i] = (i % 2 == 1); byn[i] = 1'b0;
            end
        end else if (m_div == CDIV - 1) begin
            m_div = 0;
            e_hs = !(m_h >= HA + HF && m_h < HA + HF + HS);
            e_vs = !(m_v >= VA + VF && m_v < VA + VF + VS);
            e_rgb = 3'd0;
            if (m_h < HA && m_v < VA) begin
                for (int i = NB - 1; i >= 0; i--) begin
                    if ((m_h - bx[i]) * (m_h - bx[i]) + (m_v - by[i]) * (m_v - by[i]) <= RAD * RAD)
                        e_rgb = 3'(i + 1);
                end
            end
            if (m_h == 0 && m_v == VA && !PAUSE) begin
                if (m_frame == FDIV - 1) begin
                    m_frame = 0;
                    s = int'(SPEED) + 1;
                    for (int i = 0; i < NB; i++) begin
                        axis_step(bx[i], bxn[i], s, HA - 1 - RAD, bx[i], bxn[i]);
                        axis_step(by[i], byn[i], s, VA - 1 - RAD, by[i], byn[i]);
                    end
                end else begin
                    m_frame = m_frame + 1;
                end
            end
            m_h = m_h + 1;
            if (m_h == HT) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end
        end else begin
            m_div = m_div + 1;
        end
    endtask

    // one clock: model follows the edge, outputs are then sampled at negedge
    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        RESET = 1'b1; PAUSE = 1'b0; SPEED = 2'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if ({HSYNC, VSYNC, R, G, B} !== 5'b11000) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got=%b expected=11000", cyc, {HSYNC, VSYNC, R, G, B});
            end
        end
        RESET = 1'b0;
    endtask

    task automatic test_sync_timing();
        int hf0 = -1, hf1 = -1, hr = -1, vf0 = -1, vf1 = -1, vr = -1;
        logic ph, pv;
        ph = HSYNC; pv = VSYNC;
        for (int k = 0; k < 3 * FRAME_CYC; k++) begin
            tick();
            n_cmp++;
            if ({HSYNC, VSYNC, R, G, B} !== {e_hs, e_vs, e_rgb}) begin
                n_fail++;
                if (n_fail <= 20) $display("FAIL sync_pixel cyc=%0d got=%b expected=%b", cyc, {HSYNC, VSYNC, R, G, B}, {e_hs, e_vs, e_rgb});
            end
            if (ph && !HSYNC) begin if (hf0 < 0) hf0 = cyc; else if (hf1 < 0) hf1 = cyc; end
            if (!ph && HSYNC && hf0 >= 0 && hr < 0) hr = cyc;
            if (pv && !VSYNC) begin if (vf0 < 0) vf0 = cyc; else if (vf1 < 0) vf1 = cyc; end
            if (!pv && VSYNC && vf0 >= 0 && vr < 0) vr = cyc;
            ph = HSYNC; pv = VSYNC;
            if (hf1 >= 0 && hr >= 0 && vf1 >= 0 && vr >= 0) break;
        end
        n_cmp++;
        if (hf1 - hf0 != HT * CDIV || hf0 < 0 || hf1 < 0) begin
            n_fail++; $display("FAIL hsync_period got=%0d expected=%0d", hf1 - hf0, HT * CDIV);
        end
        n_cmp++;
        if (hr - hf0 != HS * CDIV || hr < 0) begin
            n_fail++; $display("FAIL hsync_low_width got=%0d expected=%0d", hr - hf0, HS * CDIV);
        end
        n_cmp++;
        if (vf1 - vf0 != FRAME_CYC || vf0 < 0 || vf1 < 0) begin
            n_fail++; $display("FAIL vsync_period got=%0d expected=%0d", vf1 - vf0, FRAME_CYC);
        end
        n_cmp++;
        if (vr - vf0 != VS * HT * CDIV || vr < 0) begin
            n_fail++; $display("FAIL vsync_low_width got=%0d expected=%0d", vr - vf0, VS * HT * CDIV);
        end
    endtask

    task automatic test_motion();
        bit seen_b0 = 1'b0, seen_b1 = 1'b0;
        SPEED = 2'd3;
        for (int k = 0; k < 4 * FRAME_CYC; k++) begin
            tick();
            n_cmp++;
            if ({HSYNC, VSYNC, R, G, B} !== {e_hs, e_vs, e_rgb}) begin
                n_fail++;
                if (n_fail <= 20) $display("FAIL motion_pixel cyc=%0d got=%b expected=%b", cyc, {HSYNC, VSYNC, R, G, B}, {e_hs, e_vs, e_rgb});
            end
            if ({R, G, B} === 3'b001) seen_b0 = 1'b1;
            if ({R, G, B} === 3'b010) seen_b1 = 1'b1;
            if (k >= 2 * FRAME_CYC && $urandom_range(0, 999) == 0) SPEED = 2'($urandom_range(0, 3));
        end
        n_cmp++;
        if (!seen_b0 || !seen_b1) begin
            n_fail++; $display("FAIL ball_colours_visible got=%b%b expected=11", seen_b0, seen_b1);
        end
    endtask

    task automatic test_pause();
        int n_vf = 0;
        logic pv;
        PAUSE = 1'b1;
        pv = VSYNC;
        for (int k = 0; k < 3 * FRAME_CYC; k++) begin
            tick();
            n_cmp++;
            if ({HSYNC, VSYNC, R, G, B} !== {e_hs, e_vs, e_rgb}) begin
                n_fail++;
                if (n_fail <= 20) $display("FAIL pause_pixel cyc=%0d got=%b expected=%b", cyc, {HSYNC, VSYNC, R, G, B}, {e_hs, e_vs, e_rgb});
            end
            if (pv && !VSYNC) n_vf++;
            pv = VSYNC;
            if ($urandom_range(0, 499) == 0) SPEED = 2'($urandom_range(0, 3));
        end
        n_cmp++;
        if (n_vf != 3) begin
            n_fail++; $display("FAIL pause_vsync_count got=%0d expected=3", n_vf);
        end
        PAUSE = 1'b0;
        for (int k = 0; k < 2 * FRAME_CYC; k++) begin
            tick();
            n_cmp++;
            if ({HSYNC, VSYNC, R, G, B} !== {e_hs, e_vs, e_rgb}) begin
                n_fail++;
                if (n_fail <= 20) $display("FAIL resume_pixel cyc=%0d got=%b expected=%b", cyc, {HSYNC, VSYNC, R, G, B}, {e_hs, e_vs, e_rgb});
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit found = 1'b0;
        int n;
        for (int k = 0; k < 2 * FRAME_CYC; k++) begin
            tick();
            n_cmp++;
            if ({HSYNC, VSYNC, R, G, B} !== {e_hs, e_vs, e_rgb}) begin
                n_fail++;
                if (n_fail <= 20) $display("FAIL midframe_pixel cyc=%0d got=%b expected=%b", cyc, {HSYNC, VSYNC, R, G, B}, {e_hs, e_vs, e_rgb});
            end
            if (m_h == 60 && m_v == 10 && m_div == 0) begin found = 1'b1; break; end
        end
        n_cmp++;
        if (!found) begin
            n_fail++; $display("FAIL midframe_reach got=0 expected=1");
        end
        RESET = 1'b1;
        tick();
        n_cmp++;
        if ({HSYNC, VSYNC, R, G, B} !== 5'b11000) begin
            n_fail++; $display("FAIL midframe_reset_outputs got=%b expected=11000", {HSYNC, VSYNC, R, G, B});
        end
        RESET = 1'b0;
        n = 0;
        found = 1'b0;
        for (int k = 0; k < 2 * HT * CDIV; k++) begin
            tick();
            n++;
            n_cmp++;
            if ({HSYNC, VSYNC, R, G, B} !== {e_hs, e_vs, e_rgb}) begin
                n_fail++;
                if (n_fail <= 20) $display("FAIL restart_pixel cyc=%0d got=%b expected=%b", cyc, {HSYNC, VSYNC, R, G, B}, {e_hs, e_vs, e_rgb});
            end
            if (!HSYNC) begin found = 1'b1; break; end
        end
        n_cmp++;
        if (!found || n != (HA + HF + 1) * CDIV) begin
            n_fail++; $display("FAIL first_hsync_after_reset got=%0d expected=%0d", n, (HA + HF + 1) * CDIV);
        end
    endtask

    initial begin
        test_reset();
        test_sync_timing();
        test_motion();
        test_pause();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
